// File: rtl/mult_operand_feeder.sv
// mult_operand_feeder: operand-pair FIFO that issues pairs one at a time to a start/busy/done multiplier.
// Define FEEDER_STATS_EN to add the saturating issue_count output.
module mult_operand_feeder #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [7:0]               s_a,
    input  logic [7:0]               s_b,
    output logic                     mul_valid,
    output logic [7:0]               mul_a,
    output logic [7:0]               mul_b,
    input  logic                     mul_busy,
    input  logic                     mul_done,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     idle,
    output logic                     err
`ifdef FEEDER_STATS_EN
    ,
    output logic [15:0]              issue_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;
    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [15:0]     mem_q [DEPTH];
    logic            mul_valid_q, mul_valid_d;
    logic [7:0]      mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic            wait_q, wait_d;
    logic            err_q, err_d;
    logic            push, pop, timeout;
    always_comb begin
        s_ready     = count_q != FULL && !reset;
        push        = s_valid && s_ready;
        pop         = state_q == IDLE && count_q != '0 && !mul_busy;
        wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);
        mul_valid_d = pop;
        {mul_a_d, mul_b_d} = pop ? mem_q[rd_ptr_q] : {mul_a_q, mul_b_q};
        // the multiplier gets two cycles after the start pulse to show busy or done
        timeout     = state_q == WAIT_BUSY && !mul_busy && !mul_done && wait_q;
        wait_d      = state_q == WAIT_BUSY && !mul_busy && !mul_done && !wait_q;
        err_d       = err_q || timeout || (state_q == IDLE && mul_done);
        state_d     = state_q == IDLE      ? (pop ? WAIT_BUSY : IDLE) :
                      state_q == WAIT_BUSY ? (mul_done ? IDLE : mul_busy ? WAIT_DONE : timeout ? IDLE : WAIT_BUSY) :
                                             (mul_done ? IDLE : WAIT_DONE);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mul_valid_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            wait_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mul_valid_q <= mul_valid_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            wait_q      <= wait_d;
            err_q       <= err_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {s_a, s_b};
    end
    assign mul_valid = mul_valid_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign level     = count_q;
    assign idle      = count_q == '0 && state_q == IDLE;
    assign err       = err_q;
`ifdef FEEDER_STATS_EN
    logic [15:0] issue_count_q, issue_count_d;
    always_comb issue_count_d = (pop && issue_count_q != 16'hFFFF) ? issue_count_q + 16'd1 : issue_count_q;
    always_ff @(posedge clk) begin
        if (reset) issue_count_q <= '0;
        else issue_count_q <= issue_count_d;
    end
    assign issue_count = issue_count_q;
`endif
endmodule
